// File: rtl/mem_ctrl_if.sv
// Bus between the LC-3b datapath, the memory-access controller and mem16.
// The slave side is the controller; the master side is the datapath plus memory.
interface mem_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic        req_word;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rdy;
    logic [15:0] rdata;
    logic [15:0] mem_addr;
    logic        mem_write;
    logic [15:0] mem_in;
    logic [15:0] mem_out;

    modport master (
        output req_valid, req_we, req_word, req_addr, req_wdata, mem_out,
        input  rdy, rdata, mem_addr, mem_write, mem_in
    );

    modport slave (
        input  req_valid, req_we, req_word, req_addr, req_wdata, mem_out,
        output rdy, rdata, mem_addr, mem_write, mem_in
    );
endinterface

// File: rtl/mem_ctrl.sv
// LC-3b memory-access controller: latches one request, waits a fixed latency,
// returns rdy; byte stores go through a read-modify-write of the whole word.
module mem_ctrl #(
    parameter int LATENCY = 5
) (
    input  logic      clk,
    input  logic      reset,
    mem_ctrl_if.slave bus
);

    localparam int CW = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {IDLE, WAIT, RMW_WR, DONE} state_t;

    state_t        state;
    state_t        nextState;
    logic [CW-1:0] counter;
    logic [15:0]   addrQ;
    logic [15:0]   wdataQ;
    logic [15:0]   mergeQ;
    logic [15:0]   rdataQ;
    logic          weQ;
    logic          wordQ;

    logic          capture;
    logic          lastCycle;
    logic          byteWrite;
    logic          loadRead;
    logic [15:0]   curAddr;
    logic          curWord;
    logic [7:0]    laneByte;

    assign capture   = (state == IDLE) && bus.req_valid;
    assign byteWrite = weQ && !wordQ;

    // In IDLE the request lines are live; afterwards only the latched copy counts.
    assign curAddr  = (state == IDLE) ? bus.req_addr : addrQ;
    assign curWord  = (state == IDLE) ? bus.req_word : wordQ;
    assign laneByte = curAddr[0] ? bus.mem_out[15:8] : bus.mem_out[7:0];

    always_comb begin
        nextState = state;
        lastCycle = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if ((LATENCY == 1) && !(bus.req_we && !bus.req_word))
                        nextState = DONE;
                    else
                        nextState = WAIT;
                end
            end
            WAIT: begin
                // A byte store spends one extra cycle so the merge read sees full latency.
                lastCycle = byteWrite ? (counter == CW'(LATENCY))
                                      : (counter == CW'(LATENCY - 1));
                if (lastCycle)
                    nextState = byteWrite ? RMW_WR : DONE;
            end
            RMW_WR:  nextState = IDLE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign loadRead = ((state == WAIT) && lastCycle && !weQ)
                   || (capture && (LATENCY == 1) && !bus.req_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            addrQ   <= '0;
            wdataQ  <= '0;
            mergeQ  <= '0;
            rdataQ  <= '0;
            weQ     <= 1'b0;
            wordQ   <= 1'b0;
        end else begin
            state <= nextState;
            if (capture) begin
                addrQ   <= bus.req_addr;
                wdataQ  <= bus.req_wdata;
                weQ     <= bus.req_we;
                wordQ   <= bus.req_word;
                counter <= CW'(1);
            end else if (state == WAIT) begin
                counter <= counter + 1'b1;
            end
            if (loadRead)
                rdataQ <= curWord ? bus.mem_out : {8'h00, laneByte};
            if ((state == WAIT) && lastCycle && byteWrite)
                mergeQ <= addrQ[0] ? {wdataQ[7:0], bus.mem_out[7:0]}
                                   : {bus.mem_out[15:8], wdataQ[7:0]};
        end
    end

    // With single-cycle latency the read completes on the capture edge,
    // so the request address must already reach mem16 while still in IDLE.
    always_comb begin
        bus.mem_addr = 16'h0000;
        if (state != IDLE)
            bus.mem_addr = {addrQ[15:1], 1'b0};
        else if ((LATENCY == 1) && bus.req_valid && !reset)
            bus.mem_addr = {bus.req_addr[15:1], 1'b0};
    end

    always_comb begin
        bus.mem_in    = 16'h0000;
        bus.mem_write = 1'b0;
        if (state == RMW_WR) begin
            bus.mem_in    = mergeQ;
            bus.mem_write = !reset;
        end else if ((state == DONE) && weQ && wordQ) begin
            bus.mem_in    = wdataQ;
            bus.mem_write = !reset;
        end
    end

    assign bus.rdy   = (state == DONE) || (state == RMW_WR);
    assign bus.rdata = rdataQ;

endmodule
